// File: rtl/viterbi_chk_pkg.sv
// Shared types and default sizing for the Viterbi BER checker.
package viterbi_chk_pkg;

    typedef enum logic [0:0] {CHK_SEARCH, CHK_LOCKED} chk_state_t;

    localparam int unsigned DEF_MAX_LAT  = 64;
    localparam int unsigned DEF_LOCK_CNT = 16;
    localparam int unsigned DEF_LOSS_CNT = 8;
    localparam int unsigned DEF_CW       = 32;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc && (q != '1)) begin
            q <= q + W'(1);
        end
    end

endmodule

// File: rtl/viterbi_ber_checker.sv
// BER monitor: finds decoder latency against a TX bit history, then counts bits/errors.
// Optional first-error index capture is enabled by defining BER_FIRST_ERR_EN.
module viterbi_ber_checker
    import viterbi_chk_pkg::*;
#(
    parameter int unsigned MAX_LAT  = DEF_MAX_LAT,
    parameter int unsigned LOCK_CNT = DEF_LOCK_CNT,
    parameter int unsigned LOSS_CNT = DEF_LOSS_CNT,
    parameter int unsigned CW       = DEF_CW
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       tx_valid_i,
    input  logic                       tx_bit_i,
    input  logic                       rx_valid_i,
    input  logic                       rx_bit_i,
    input  logic                       clear_i,
    output logic                       locked_o,
    output logic [$clog2(MAX_LAT)-1:0] lat_o,
    output logic [CW-1:0]              bit_cnt_o,
    output logic [CW-1:0]              err_cnt_o,
    output logic                       lost_o,
    output logic [CW-1:0]              first_err_idx_o
);

    localparam int unsigned LW = $clog2(MAX_LAT);
    localparam int unsigned RW = $clog2(LOCK_CNT + 1);
    localparam int unsigned MW = $clog2(LOSS_CNT + 1);

    localparam logic [LW-1:0] LAT_LAST  = LW'(MAX_LAT - 1);
    localparam logic [RW-1:0] RUN_LAST  = RW'(LOCK_CNT - 1);
    localparam logic [MW-1:0] MISS_LAST = MW'(LOSS_CNT - 1);

    chk_state_t          state, state_n;
    logic [MAX_LAT-1:0]  hist;
    logic [LW-1:0]       lat, lat_n, lat_inc;
    logic [RW-1:0]       run, run_n;
    logic [MW-1:0]       miss, miss_n;
    logic                match;
    logic                bit_inc, err_inc, lose;

    // Compare uses the history as it was before this cycle's tx shift.
    assign match   = (rx_bit_i == hist[lat]);
    assign lat_inc = (lat == LAT_LAST) ? '0 : lat + LW'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= CHK_SEARCH;
            lat    <= '0;
            run    <= '0;
            miss   <= '0;
            hist   <= '0;
            lost_o <= 1'b0;
        end else begin
            state  <= state_n;
            lat    <= lat_n;
            run    <= run_n;
            miss   <= miss_n;
            lost_o <= lose;
            if (tx_valid_i) begin
                hist <= {hist[MAX_LAT-2:0], tx_bit_i};
            end
        end
    end

    always_comb begin
        state_n = state;
        lat_n   = lat;
        run_n   = run;
        miss_n  = miss;
        if (rx_valid_i) begin
            case (state)
                CHK_SEARCH: begin
                    miss_n = '0;
                    if (match) begin
                        if (run == RUN_LAST) begin
                            state_n = CHK_LOCKED;
                            run_n   = '0;
                        end else begin
                            run_n = run + RW'(1);
                        end
                    end else begin
                        run_n = '0;
                        lat_n = lat_inc;
                    end
                end
                CHK_LOCKED: begin
                    if (match) begin
                        miss_n = '0;
                    end else if (miss == MISS_LAST) begin
                        state_n = CHK_SEARCH;
                        lat_n   = lat_inc;
                        run_n   = '0;
                        miss_n  = '0;
                    end else begin
                        miss_n = miss + MW'(1);
                    end
                end
                default: state_n = CHK_SEARCH;
            endcase
        end
    end

    always_comb begin
        locked_o = (state == CHK_LOCKED);
        bit_inc  = rx_valid_i && (state == CHK_LOCKED);
        err_inc  = bit_inc && !match;
        lose     = err_inc && (miss == MISS_LAST);
    end

    assign lat_o = lat;

    sat_counter #(.W(CW)) u_bit_cnt (
        .clk (clk),
        .rst (rst),
        .inc (bit_inc),
        .clr (clear_i),
        .q   (bit_cnt_o)
    );

    sat_counter #(.W(CW)) u_err_cnt (
        .clk (clk),
        .rst (rst),
        .inc (err_inc),
        .clr (clear_i),
        .q   (err_cnt_o)
    );

`ifdef BER_FIRST_ERR_EN
    logic          first_seen;
    logic [CW-1:0] first_idx;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            first_seen <= 1'b0;
            first_idx  <= '1;
        end else if (clear_i) begin
            first_seen <= 1'b0;
            first_idx  <= '1;
        end else if (err_inc && !first_seen) begin
            first_seen <= 1'b1;
            first_idx  <= bit_cnt_o;
        end
    end

    assign first_err_idx_o = first_idx;
`else
    assign first_err_idx_o = '1;
`endif

endmodule
